// File: rtl/game_ctrl_score.sv
// Game-level controller: IDLE/PLAY/OVER sequencing, score-dependent move tick,
// BCD score and high score, and active-low 7-segment decode of the score.
module game_ctrl_score #(
  parameter int unsigned TICK_BASE = 2_500_000,
  parameter int unsigned TICK_STEP = 50_000,
  parameter int unsigned TICK_MIN  = 750_000,
  parameter int unsigned SCORE_MAX = 99
) (
  input  logic       clk_d,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       eat,
  input  logic       game_over,
  output logic       start,
  output logic       updateclock,
  output logic [1:0] state,
  output logic [7:0] score_bcd,
  output logic [7:0] hiscore_bcd,
  output logic [6:0] seg_tens,
  output logic [6:0] seg_ones
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    OVER = 2'b10
  } state_t;

  state_t      fsm;
  logic        btn_q;
  logic        eat_q;
  logic        btn_rise;
  logic        eat_rise;
  logic [6:0]  score_bin;
  logic [31:0] cnt;
  logic [39:0] dec;
  logic [39:0] period;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return ~7'b0111111;
      4'd1:    return ~7'b0000110;
      4'd2:    return ~7'b1011011;
      4'd3:    return ~7'b1001111;
      4'd4:    return ~7'b1100110;
      4'd5:    return ~7'b1101101;
      4'd6:    return ~7'b1111101;
      4'd7:    return ~7'b0000111;
      4'd8:    return ~7'b1111111;
      4'd9:    return ~7'b1101111;
      default: return 7'h7F;
    endcase
  endfunction

  assign btn_rise = btn_start & ~btn_q;
  assign eat_rise = eat & ~eat_q;
  assign state    = fsm;

  // Clamp is decided by comparing the decrement against the headroom, so the
  // subtraction is only taken when it cannot wrap.
  always_comb begin
    dec = 40'(TICK_STEP) * 40'(score_bin);
    if (dec + 40'(TICK_MIN) >= 40'(TICK_BASE)) period = 40'(TICK_MIN);
    else                                       period = 40'(TICK_BASE) - dec;
  end

  always_comb begin
    seg_tens = seg7(score_bcd[7:4]);
    seg_ones = seg7(score_bcd[3:0]);
  end

  always_ff @(posedge clk_d) begin
    if (reset) begin
      fsm         <= IDLE;
      start       <= 1'b0;
      updateclock <= 1'b0;
      score_bcd   <= '0;
      score_bin   <= '0;
      hiscore_bcd <= '0;
      cnt         <= '0;
      btn_q       <= 1'b0;
      eat_q       <= 1'b0;
    end else begin
      btn_q       <= btn_start;
      eat_q       <= eat;
      updateclock <= 1'b0;
      case (fsm)
        IDLE, OVER: begin
          cnt <= '0;
          if (btn_rise) begin
            fsm       <= PLAY;
            start     <= 1'b1;
            score_bcd <= '0;
            score_bin <= '0;
          end
        end
        PLAY: begin
          if (game_over) begin
            // A tick due on this edge is dropped so no pulse lands in OVER.
            fsm   <= OVER;
            start <= 1'b0;
            cnt   <= '0;
            if (score_bcd > hiscore_bcd) hiscore_bcd <= score_bcd;
          end else begin
            if (eat_rise && (score_bin < 7'(SCORE_MAX))) begin
              score_bcd <= bcd_inc(score_bcd);
              score_bin <= score_bin + 7'd1;
            end
            if (40'(cnt) >= period - 40'd1) begin
              updateclock <= 1'b1;
              cnt         <= '0;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
        end
        default: begin
          fsm   <= IDLE;
          start <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_ctrl_score.sv
// Scoreboard bench for game_ctrl_score: stimulus queues expected snapshots and
// tick times; a negedge monitor pops and compares them against the outputs.
module tb_game_ctrl_score;

  localparam int unsigned P_BASE = 200;
  localparam int unsigned P_STEP = 10;
  localparam int unsigned P_MIN  = 20;

  logic       clk_d = 1'b0;
  logic       reset = 1'b1;
  logic       btn_start = 1'b0;
  logic       eat = 1'b0;
  logic       game_over = 1'b0;
  logic       start;
  logic       updateclock;
  logic [1:0] state;
  logic [7:0] score_bcd;
  logic [7:0] hiscore_bcd;
  logic [6:0] seg_tens;
  logic [6:0] seg_ones;

  game_ctrl_score #(
    .TICK_BASE(P_BASE),
    .TICK_STEP(P_STEP),
    .TICK_MIN (P_MIN),
    .SCORE_MAX(99)
  ) dut (
    .clk_d      (clk_d),
    .reset      (reset),
    .btn_start  (btn_start),
    .eat        (eat),
    .game_over  (game_over),
    .start      (start),
    .updateclock(updateclock),
    .state      (state),
    .score_bcd  (score_bcd),
    .hiscore_bcd(hiscore_bcd),
    .seg_tens   (seg_tens),
    .seg_ones   (seg_ones)
  );

  always #5 clk_d = ~clk_d;

  typedef struct {
    int unsigned cyc;
    logic [1:0]  st;
    logic        st_start;
    logic [7:0]  score;
    logic [7:0]  hi;
    logic        upd_chk;
    logic        upd;
  } snap_t;

  snap_t       snap_q[$];
  string       name_q[$];
  int unsigned tick_q[$];
  int unsigned cyc = 0;
  bit          tick_chk = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  always @(posedge clk_d) cyc <= cyc + 1;

  function automatic logic [6:0] seg_exp(input logic [3:0] d);
    logic [6:0] tbl [10];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    if (d > 4'd9) return 7'h7F;
    return tbl[d];
  endfunction

  function automatic void report(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Monitor
  always @(negedge clk_d) begin
    snap_t s;
    string nm;
    while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
      s  = snap_q.pop_front();
      nm = name_q.pop_front();
      if (s.cyc != cyc) begin
        report({nm, "_missed"}, 64'(cyc), 64'(s.cyc));
      end else begin
        report(nm, 64'({state, start, score_bcd, hiscore_bcd, seg_tens, seg_ones}),
               64'({s.st, s.st_start, s.score, s.hi, seg_exp(s.score[7:4]), seg_exp(s.score[3:0])}));
        if (s.upd_chk) report({nm, "_upd"}, 64'(updateclock), 64'(s.upd));
      end
    end
    if (updateclock) begin
      report("tick_only_in_play", 64'(state), 64'(2'b01));
      if (tick_chk) begin
        if (tick_q.size() == 0) report("tick_unexpected", 64'(cyc), 64'(0));
        else report("tick_time", 64'(cyc), 64'(tick_q.pop_front()));
      end
    end
    while (tick_chk && tick_q.size() > 0 && tick_q[0] < cyc)
      report("tick_missing", 64'(cyc), 64'(tick_q.pop_front()));
  end

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk_d);
      #1;
    end
  endtask

  task automatic run_to(input int unsigned n);
    while (cyc < n) step(1);
  endtask

  task automatic expect_snap(input string nm, input logic [1:0] st, input logic st_start,
                             input logic [7:0] sc, input logic [7:0] hi,
                             input logic upd_chk, input logic upd);
    snap_t s;
    s.cyc = cyc; s.st = st; s.st_start = st_start; s.score = sc; s.hi = hi;
    s.upd_chk = upd_chk; s.upd = upd;
    snap_q.push_back(s);
    name_q.push_back(nm);
  endtask

  task automatic pulse_eat(input int unsigned n);
    repeat (n) begin
      eat = 1'b1; step(1);
      eat = 1'b0; step(1);
    end
  endtask

  // Sync to a tick, then require the next two exactly p apart.
  task automatic check_period(input string nm, input int unsigned p);
    int unsigned k = 0;
    int unsigned t;
    tick_chk = 1'b0;
    while (!updateclock && k < 300) begin step(1); k++; end
    if (!updateclock) begin
      report({nm, "_wait"}, 64'(0), 64'(1));
    end else begin
      t = cyc;
      step(1);
      tick_chk = 1'b1;
      tick_q.push_back(t + p);
      tick_q.push_back(t + 2 * p);
      run_to(t + 2 * p + 2);
      tick_chk = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned e, t2, x;
    step(3);
    expect_snap("reset_state", 2'b00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    reset = 1'b0;
    step(2);

    // Enter PLAY; ticks at period 200 from entry
    btn_start = 1'b1; step(1);
    e = cyc;
    expect_snap("enter_play", 2'b01, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0);
    tick_chk = 1'b1;
    tick_q.push_back(e + P_BASE);
    tick_q.push_back(e + 2 * P_BASE);
    step(2); btn_start = 1'b0;
    run_to(e + 2 * P_BASE + 1);

    // Counter at 195 when period drops to 190: fires on the next cycle
    t2 = e + 2 * P_BASE;
    x  = t2 + 194;
    run_to(x);
    eat = 1'b1; step(1); eat = 1'b0;
    expect_snap("shrink_score", 2'b01, 1'b1, 8'h01, 8'h00, 1'b0, 1'b0);
    tick_q.push_back(t2 + 196);
    tick_q.push_back(t2 + 196 + 190);
    run_to(t2 + 196 + 191);
    tick_chk = 1'b0;

    // 12 points, then period 80
    pulse_eat(11);
    expect_snap("score_12", 2'b01, 1'b1, 8'h12, 8'h00, 1'b0, 1'b0);
    check_period("period_12", P_BASE - 12 * P_STEP);
    eat = 1'b1; step(10); eat = 1'b0; step(1);
    expect_snap("held_eat_once", 2'b01, 1'b1, 8'h13, 8'h00, 1'b0, 1'b0);

    // Saturation at 99 and period floor
    pulse_eat(86);
    expect_snap("score_99", 2'b01, 1'b1, 8'h99, 8'h00, 1'b0, 1'b0);
    pulse_eat(3);
    expect_snap("score_sat", 2'b01, 1'b1, 8'h99, 8'h00, 1'b0, 1'b0);
    check_period("period_min", P_MIN);

    game_over = 1'b1; step(1);
    expect_snap("over_99", 2'b10, 1'b0, 8'h99, 8'h99, 1'b1, 1'b0);
    game_over = 1'b0; step(3);
    expect_snap("over_hold", 2'b10, 1'b0, 8'h99, 8'h99, 1'b1, 1'b0);

    reset = 1'b1; step(1);
    expect_snap("reset_over", 2'b00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    reset = 1'b0; step(1);

    game_over = 1'b1; step(2);
    expect_snap("idle_ignores_go", 2'b00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    game_over = 1'b0; step(1);

    // Score 07, game_over wins over simultaneous eat
    btn_start = 1'b1; step(1); btn_start = 1'b0;
    expect_snap("play_2", 2'b01, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
    pulse_eat(7);
    expect_snap("score_07", 2'b01, 1'b1, 8'h07, 8'h00, 1'b0, 1'b0);
    eat = 1'b1; game_over = 1'b1; step(1);
    expect_snap("go_beats_eat", 2'b10, 1'b0, 8'h07, 8'h07, 1'b1, 1'b0);
    eat = 1'b0; tick_chk = 1'b1;
    step(5); game_over = 1'b0; step(1);
    expect_snap("over_quiet", 2'b10, 1'b0, 8'h07, 8'h07, 1'b1, 1'b0);
    tick_chk = 1'b0;

    btn_start = 1'b1; step(1); btn_start = 1'b0;
    expect_snap("replay_keep_hi", 2'b01, 1'b1, 8'h00, 8'h07, 1'b0, 1'b0);
    step(1);
    pulse_eat(3);
    game_over = 1'b1; step(1);
    expect_snap("over_03_hi07", 2'b10, 1'b0, 8'h03, 8'h07, 1'b1, 1'b0);
    game_over = 1'b0; step(1);

    // Hiscore 40, then reset mid-play at 25
    btn_start = 1'b1; step(1); btn_start = 1'b0;
    pulse_eat(40);
    game_over = 1'b1; step(1);
    expect_snap("over_40", 2'b10, 1'b0, 8'h40, 8'h40, 1'b1, 1'b0);
    game_over = 1'b0;
    btn_start = 1'b1; step(1); btn_start = 1'b0;
    pulse_eat(25);
    expect_snap("score_25", 2'b01, 1'b1, 8'h25, 8'h40, 1'b0, 1'b0);
    reset = 1'b1; step(1);
    expect_snap("reset_midplay", 2'b00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    reset = 1'b0; step(2);
    expect_snap("idle_after_reset", 2'b00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
